// File: rtl/riscv_mdu_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mdu_pkg
//
// Shared execute-stage definitions for the multiply/divide unit: the
// M-extension operation codes (equal to the instruction funct3 field),
// the MDU state encoding and small decode helpers used by the unit.
// -----------------------------------------------------------------------------
package riscv_mdu_pkg;

    // M-extension operation codes (funct3 of the OP/OP-32 M instructions)
    localparam int MDU_OP_WIDTH = 3;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'b000;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'b001;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'b010;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'b011;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'b100;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'b101;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'b110;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_t;

    // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM
    function automatic logic mdu_a_signed(input logic [MDU_OP_WIDTH-1:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV)  || (op == MDU_REM);
    endfunction

    // rs2 is interpreted as signed for MULH, DIV and REM only
    function automatic logic mdu_b_signed(input logic [MDU_OP_WIDTH-1:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // All divide/remainder ops have funct3[2] set
    function automatic logic mdu_is_div(input logic [MDU_OP_WIDTH-1:0] op);
        return op[2];
    endfunction

    function automatic logic mdu_is_rem(input logic [MDU_OP_WIDTH-1:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/riscv_mdu.sv
// -----------------------------------------------------------------------------
// riscv_mdu
//
// Iterative RV32M/RV64M multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide, one iteration per clock, on magnitudes; the sign is fixed
// up in a final FIX cycle. Divide-by-zero and signed overflow complete through
// a one-cycle fast path.
//
// Ports
//   clk_i     in   clock, rising edge
//   rst_ni    in   asynchronous active-low reset
//   valid_i   in   operation request, taken when ready_o is high
//   op_i      in   operation code (funct3)
//   a_i       in   rs1 operand
//   b_i       in   rs2 operand
//   flush_i   in   abort any in-flight operation
//   ready_o   out  unit can accept a request this cycle
//   valid_o   out  one-cycle pulse, result_o is valid
//   result_o  out  result, held until the next accepted request completes
// -----------------------------------------------------------------------------
module riscv_mdu
    import riscv_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    input  logic [MDU_OP_WIDTH-1:0] op_i,
    input  logic [XLEN-1:0]         a_i,
    input  logic [XLEN-1:0]         b_i,
    input  logic                    flush_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [XLEN-1:0]         result_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    mdu_state_t              state_reg;
    mdu_state_t              state_next;

    logic [MDU_OP_WIDTH-1:0] op_reg;
    logic                    sign_a_reg;
    logic                    sign_b_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [XLEN-1:0]         result_reg;

    // acc_reg: upper product half / partial remainder
    // lo_reg : multiplier shifting out, product low half shifting in
    //          (or dividend shifting out, quotient shifting in)
    // opnd_reg: multiplicand / divisor magnitude
    logic [XLEN-1:0]         acc_reg;
    logic [XLEN-1:0]         acc_next;
    logic [XLEN-1:0]         lo_reg;
    logic [XLEN-1:0]         lo_next;
    logic [XLEN-1:0]         opnd_reg;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic            accept;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic            fast;
    logic [XLEN-1:0] fast_res;

    assign accept = valid_i && ready_o && !flush_i;

    assign a_neg = mdu_a_signed(op_i) & a_i[XLEN-1];
    assign b_neg = mdu_b_signed(op_i) & b_i[XLEN-1];

    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    assign mag_a = a_neg ? -a_i : a_i;
    assign mag_b = b_neg ? -b_i : b_i;

    assign div_zero = mdu_is_div(op_i) && (b_i == '0);
    // Signed overflow only for DIV/REM (funct3[0] clear among the divides)
    assign div_ovf  = mdu_is_div(op_i) && !op_i[0] &&
                      (a_i == MOST_NEG) && (b_i == '1);
    assign fast     = div_zero || div_ovf;

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = mdu_is_rem(op_i) ? a_i : '1;
        end else begin
            fast_res = mdu_is_rem(op_i) ? '0 : a_i;
        end
    end

    // -------------------------------------------------------------------------
    // One iteration of shift-add multiply or restoring divide
    // -------------------------------------------------------------------------
    logic [XLEN:0] mul_sum;
    logic [XLEN:0] rem_shift;
    logic          rem_ge;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole product right by one.
        mul_sum   = {1'b0, acc_reg} + {1'b0, (lo_reg[0] ? opnd_reg : '0)};
        // Divide: shift the next dividend bit into the partial remainder
        // (XLEN+1 bits so the shifted value never overflows).
        rem_shift = {acc_reg, lo_reg[XLEN-1]};
        rem_ge    = rem_shift >= {1'b0, opnd_reg};

        if (mdu_is_div(op_reg)) begin
            acc_next = rem_ge ? XLEN'(rem_shift - {1'b0, opnd_reg})
                              : rem_shift[XLEN-1:0];
            lo_next  = {lo_reg[XLEN-2:0], rem_ge};
        end else begin
            acc_next = mul_sum[XLEN:1];
            lo_next  = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    // -------------------------------------------------------------------------
    // Sign correction and result selection for the FIX cycle
    // -------------------------------------------------------------------------
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    assign product  = {acc_reg, lo_reg};
    assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -product : product;
    assign quot_fix = (sign_a_reg ^ sign_b_reg) ? -lo_reg  : lo_reg;
    // Remainder follows the sign of the dividend
    assign rem_fix  = sign_a_reg ? -acc_reg : acc_reg;

    always_comb begin
        fix_res = '0;
        case (op_reg)
            MDU_MUL:                         fix_res = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               fix_res = quot_fix;
            MDU_REM, MDU_REMU:               fix_res = rem_fix;
            default:                         fix_res = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (accept) begin
                    state_next = fast ? DONE : BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = flush_i ? IDLE : DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        ready_o = (state_reg == IDLE) || (state_reg == DONE);
        valid_o = (state_reg == DONE);
    end

    assign result_o = result_reg;

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            lo_reg     <= '0;
            opnd_reg   <= '0;
            result_reg <= '0;
        end else if (accept) begin
            op_reg     <= op_i;
            sign_a_reg <= a_neg;
            sign_b_reg <= b_neg;
            cnt_reg    <= CNT_W'(XLEN - 1);
            acc_reg    <= '0;
            if (mdu_is_div(op_i)) begin
                lo_reg   <= mag_a;
                opnd_reg <= mag_b;
            end else begin
                lo_reg   <= mag_b;
                opnd_reg <= mag_a;
            end
            if (fast) begin
                result_reg <= fast_res;
            end
        end else if ((state_reg == BUSY) && !flush_i) begin
            acc_reg <= acc_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg - 1'b1;
        end else if ((state_reg == FIX) && !flush_i) begin
            result_reg <= fix_res;
        end
    end

endmodule

// File: tb/tb_riscv_mdu.sv
// -----------------------------------------------------------------------------
// tb_riscv_mdu
//
// Directed bench for riscv_mdu (XLEN=32). Every request pushes the expected
// result and completion cycle (computed with plain 64-bit arithmetic) onto a
// queue; a single compare process checks ready_o, valid_o and result_o on
// every falling edge against that queue.
// -----------------------------------------------------------------------------
module tb_riscv_mdu;
    import riscv_mdu_pkg::*;

    localparam int XLEN = 32;

    logic              clk_i   = 1'b0;
    logic              rst_ni  = 1'b0;
    logic              valid_i = 1'b0;
    logic [2:0]        op_i    = '0;
    logic [XLEN-1:0]   a_i     = '0;
    logic [XLEN-1:0]   b_i     = '0;
    logic              flush_i = 1'b0;
    logic              ready_o;
    logic              valid_o;
    logic [XLEN-1:0]   result_o;

    riscv_mdu #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          valid_cycles[$];
    logic [31:0] last_res = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic logic [31:0] model_res(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            MDU_MUL:    begin p = sa * sb;           return p[31:0];  end
            MDU_MULH:   begin p = sa * sb;           return p[63:32]; end
            MDU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            MDU_MULHU:  begin p = ua * ub;           return p[63:32]; end
            MDU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            MDU_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            MDU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic logic model_fast(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        if (op[2] && b == 0) return 1'b1;
        if ((op == MDU_DIV || op == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1'b1;
        return 1'b0;
    endfunction

    // The unit can take a request unless an accepted operation is still
    // computing (its completion cycle lies in the future).
    function automatic logic model_ready(input int c);
        return !(exp_q.size() > 0 && exp_q[0].due > c);
    endfunction

    // ------------------------------------------------------- compare process
    always @(negedge clk_i) begin
        logic ev;
        logic er;
        if (!rst_ni) begin
            check("rst_ready", 32'(ready_o), 32'd1);
            check("rst_valid", 32'(valid_o), 32'd0);
            check("rst_result", result_o, 32'd0);
        end else begin
            ev = exp_q.size() > 0 && exp_q[0].due == cyc;
            er = model_ready(cyc);
            check("ready", 32'(ready_o), 32'(er));
            check("valid", 32'(valid_o), 32'(ev));
            if (ev) begin
                check("result", result_o, exp_q[0].res);
                $display("txn done cyc=%0d result=%h expected=%h", cyc, result_o, exp_q[0].res);
                last_res = exp_q[0].res;
                valid_cycles.push_back(cyc);
                void'(exp_q.pop_front());
            end else begin
                check("hold", result_o, last_res);
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    // All stimulus runs 1 time unit after a rising edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lit, input logic fast_lit, input string name);
        exp_t e;
        bit   done;
        check({name, "_model"}, model_res(op, a, b), exp_lit);
        check({name, "_fastmodel"}, 32'(model_fast(op, a, b)), 32'(fast_lit));
        op_i    = op;
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        done    = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            if (model_ready(cyc)) begin
                @(posedge clk_i); #1;
                e.res = model_res(op, a, b);
                e.due = model_fast(op, a, b) ? cyc : cyc + XLEN + 1;
                exp_q.push_back(e);
                $display("txn %s op=%0d a=%h b=%h accepted cyc=%0d", name, op, a, b, cyc);
                done = 1'b1;
            end else begin
                @(posedge clk_i); #1;
            end
        end
        if (!done) begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) begin
            @(posedge clk_i); #1;
        end
        if (exp_q.size() > 0) begin
            check("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // Main function, directed
        do_op(MDU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul");      wait_idle();
        do_op(MDU_MULH,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "mulh");     wait_idle();
        do_op(MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min"); wait_idle();
        do_op(MDU_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulhu_min");wait_idle();
        do_op(MDU_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0, "mulhsu");   wait_idle();
        do_op(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");wait_idle();
        do_op(MDU_MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, 1'b0, "mul_lo");   wait_idle();
        do_op(MDU_MULHU,  32'h1234_5678, 32'h10,        32'h0000_0001, 1'b0, "mulhu_hi"); wait_idle();
        do_op(MDU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div");      wait_idle();
        do_op(MDU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "rem");      wait_idle();
        do_op(MDU_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0, "divu");     wait_idle();
        do_op(MDU_DIV,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         1'b0, "div_nn");   wait_idle();
        do_op(MDU_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, "rem_pn");   wait_idle();
        do_op(MDU_REMU,   32'hFFFF_FFFF, 32'd16,        32'd15,        1'b0, "remu");     wait_idle();
        do_op(MDU_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, "divu_big"); wait_idle();
        do_op(MDU_DIV,    32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, "div_min1"); wait_idle();

        // Fast path: divide by zero and signed overflow
        do_op(MDU_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b1, "divu_z"); wait_idle();
        do_op(MDU_REM,  32'd100,       32'd0,         32'd100,       1'b1, "rem_z");  wait_idle();
        do_op(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ov"); wait_idle();
        do_op(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, "rem_ov"); wait_idle();

        // Two fast ops back to back: second accepted in the DONE cycle
        do_op(MDU_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "b2b_fast1");
        do_op(MDU_REMU, 32'd9, 32'd0, 32'd9,         1'b1, "b2b_fast2");
        wait_idle();
        n = valid_cycles.size();
        check("b2b_fast_gap", 32'(valid_cycles[n-1] - valid_cycles[n-2]), 32'd1);

        // Back-to-back normal ops, second request held through BUSY
        do_op(MDU_MUL,  32'd3,    32'd5, 32'd15,  1'b0, "b2b_mul");
        do_op(MDU_DIVU, 32'd1000, 32'd7, 32'd142, 1'b0, "b2b_divu");
        wait_idle();
        n = valid_cycles.size();
        check("b2b_gap", 32'(valid_cycles[n-1] - valid_cycles[n-2]), 32'd34);

        // Flush during iteration 10, with a competing request
        do_op(MDU_MUL, 32'hFFFF, 32'hFFFF, 32'hFFFE_0001, 1'b0, "flush_mul");
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        valid_i = 1'b1;
        op_i    = MDU_DIVU;
        a_i     = 32'd50;
        b_i     = 32'd0;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        exp_q.delete();
        repeat (40) @(posedge clk_i);
        #1;

        // Flush in a DONE cycle together with a new request: request dropped
        do_op(MDU_DIVU, 32'd77, 32'd0, 32'hFFFF_FFFF, 1'b1, "flush_done");
        flush_i = 1'b1;
        valid_i = 1'b1;
        op_i    = MDU_REMU;
        a_i     = 32'd33;
        b_i     = 32'd0;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;

        // Asynchronous reset during iteration 10
        do_op(MDU_MUL, 32'd11, 32'd13, 32'd143, 1'b0, "rst_mul");
        repeat (9) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        exp_q.delete();
        last_res = '0;
        #1;
        check("async_rst_ready", 32'(ready_o), 32'd1);
        check("async_rst_valid", 32'(valid_o), 32'd0);
        check("async_rst_result", result_o, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (40) @(posedge clk_i);
        #1;

        // Unit still works after the reset
        do_op(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "post_rst");
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
